// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / prefetch queue slice.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO of fetched entries; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fq_entry_t              din,
  input  logic                   pop,
  input  logic                   flush,
  output fq_entry_t              dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && (count_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: PC, one-deep in-flight read tracker, sync-read instruction memory,
// bootloader write port and a prefetch queue feeding decode.
module fetch_prefetch_unit #(
  parameter int              XLEN       = fetch_pkg::XLEN,
  parameter int              IMEM_DEPTH = 65536,
  parameter int              FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  input  logic            debug,
  input  logic [XLEN-1:0] waddr_cpu,
  input  logic [XLEN-1:0] data_cpu
);
  import fetch_pkg::*;

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] FQ_DEPTH_L = (CW+1)'(FQ_DEPTH);

  logic [XLEN-1:0] mem [IMEM_DEPTH];
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   fq_count;
  logic [CW:0]     occ;
  logic            issue, flush, pop, fq_nonempty;
  fq_entry_t       fq_head, push_entry;
  logic            unused_bits;

  always_comb begin
    // Queue slots are reserved at issue, so the in-flight read counts as occupied.
    occ           = (CW+1)'(fq_count) + (CW+1)'(inflight_q);
    issue         = !debug && !redirect && (occ < FQ_DEPTH_L);
    flush         = debug || redirect;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_fetch_q : inflight_pc_q;
    pc_fetch_d    = pc_fetch_q;
    if (debug)         pc_fetch_d = RESET_PC;
    else if (redirect) pc_fetch_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (issue)    pc_fetch_d = pc_fetch_q + XLEN'(4);
    push_entry.instr    = rdata_q;
    push_entry.pc       = inflight_pc_q;
    push_entry.pc_plus4 = inflight_pc_q + XLEN'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_fetch_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_fetch_q <= pc_fetch_d;
      inflight_q <= inflight_d;
    end
  end

  // Memory, read data and the in-flight PC are data only and survive reset.
  always_ff @(posedge clk) begin
    if (debug) mem[waddr_cpu[AW-1:0]] <= data_cpu;
    if (issue) rdata_q <= mem[pc_fetch_q[AW+1:2]];
    inflight_pc_q <= inflight_pc_d;
  end

  // A squashed return is dropped because flush wins over push in the queue.
  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (push_entry),
    .pop   (pop),
    .flush (flush),
    .dout  (fq_head),
    .count (fq_count)
  );

  assign fq_nonempty  = (fq_count != '0);
  assign out_valid    = fq_nonempty && !redirect;
  assign pop          = out_valid && out_ready;
  assign out_instr    = fq_nonempty ? fq_head.instr    : '0;
  assign out_pc       = fq_nonempty ? fq_head.pc       : '0;
  assign out_pc_plus4 = fq_nonempty ? fq_head.pc_plus4 : '0;

  assign unused_bits = ^{waddr_cpu[XLEN-1:AW], redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed plus randomized bench for fetch_prefetch_unit against a queue-based reference model.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        debug = 1'b1;
  logic [31:0] waddr_cpu = '0;
  logic [31:0] data_cpu = '0;

  always #5 clk = ~clk;

  fetch_prefetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .debug        (debug),
    .waddr_cpu    (waddr_cpu),
    .data_cpu     (data_cpu)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: queue of entries decode will see, one pending read, fetch PC, memory image.
  fq_entry_t   mq[$];
  bit          mk[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_pc;
  logic [31:0] mem_m [int];
  logic [31:0] boot [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mk.delete();
    m_pend = 1'b0;
    m_pc   = 32'h0;
  endtask

  task automatic model_edge();
    int        occ;
    int        idx;
    fq_entry_t e;
    if (debug) mem_m[int'(waddr_cpu & 32'hFFFF)] = data_cpu;
    if (rst) begin
      model_reset();
    end else if (debug) begin
      model_reset();
    end else if (redirect) begin
      mq.delete();
      mk.delete();
      m_pend = 1'b0;
      m_pc   = redirect_pc & ~32'h3;
    end else begin
      occ = mq.size() + int'(m_pend);
      if (mq.size() != 0 && out_ready) begin
        void'(mq.pop_front());
        void'(mk.pop_front());
      end
      if (m_pend) begin
        idx        = int'((m_pend_pc >> 2) & 32'hFFFF);
        e.pc       = m_pend_pc;
        e.pc_plus4 = m_pend_pc + 32'd4;
        e.instr    = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        mq.push_back(e);
        mk.push_back(mem_m.exists(idx));
      end
      if (occ < 4) begin
        m_pend    = 1'b1;
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic ev;
    @(negedge clk);
    ev = (mq.size() != 0) && !redirect;
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_pc_plus4", out_pc_plus4, mq[0].pc_plus4);
      if (mk[0]) chk("out_instr", out_instr, mq[0].instr);
    end else if (mq.size() == 0) begin
      chk("empty_instr", out_instr, 32'h0);
      chk("empty_pc", out_pc, 32'h0);
      chk("empty_pc_plus4", out_pc_plus4, 32'h0);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int k;
    k = 0;
    while (!out_valid && k < 10) begin
      cycle();
      k++;
    end
    chk(tag, k, exp_lat);
  endtask

  initial begin
    boot[0] = 32'h11; boot[1] = 32'h22; boot[2] = 32'h33; boot[3] = 32'h44;
    boot[4] = NOP_INSTR; boot[5] = 32'h55; boot[6] = 32'h66; boot[7] = 32'h77;
    model_reset();

    // Reset state, then bootload words 0..127.
    cycle();
    cycle();
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_pc", out_pc, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) begin
      waddr_cpu = i;
      data_cpu  = (i < 8) ? boot[i] : $urandom;
      cycle();
    end

    // Run after debug exit.
    debug = 1'b0;
    out_ready = 1'b1;
    wait_valid("boot_latency", 2);
    for (int i = 0; i < 4; i++) begin
      chk("boot_pc", out_pc, 32'(i * 4));
      chk("boot_instr", out_instr, boot[i]);
      cycle();
    end

    // Backpressure from a fresh start at RESET_PC.
    debug = 1'b1; waddr_cpu = 0; data_cpu = 32'h11;
    cycle();
    debug = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("bp_full_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_order_pc", out_pc, 32'(i * 4));
      cycle();
    end

    // Redirect squash with a partly drained queue.
    debug = 1'b1;
    cycle();
    debug = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1'b1;
    cycle();
    redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    chk("redir_valid_low", 32'(out_valid), 32'h0);
    cycle();
    redirect = 1'b0;
    wait_valid("redir_latency", 2);
    chk("redir_pc", out_pc, 32'h100);
    chk("redir_pc_plus4", out_pc_plus4, 32'h104);
    for (int i = 0; i < 4; i++) cycle();

    // Back-to-back redirects.
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect_pc = 32'h80;
    cycle();
    redirect = 1'b0;
    wait_valid("b2b_latency", 2);
    chk("b2b_pc", out_pc, 32'h80);
    for (int i = 0; i < 6; i++) cycle();

    // Debug and redirect together: debug wins.
    debug = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    waddr_cpu = 0; data_cpu = 32'h11;
    cycle();
    debug = 1'b0; redirect = 1'b0;
    wait_valid("dbg_redir_latency", 2);
    chk("dbg_redir_pc", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      out_ready   = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = $urandom_range(0, 32'h1FF);
      debug       = ($urandom_range(0, 99) < 3);
      waddr_cpu   = ($urandom_range(0, 3) << 16) | $urandom_range(8, 127);
      data_cpu    = $urandom;
      cycle();
    end
    redirect = 1'b0; debug = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    // Asynchronous reset between clock edges; memory must survive.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", 32'(out_valid), 32'h0);
    model_reset();
    @(posedge clk);
    model_edge();
    #1 rst = 1'b0;
    wait_valid("post_rst_latency", 2);
    chk("post_rst_pc", out_pc, 32'h0);
    chk("post_rst_instr", out_instr, 32'h11);
    for (int i = 0; i < 6; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
